// File: rtl/fstatus_pkg.sv
// Shared constants, state encoding and word packing for the F-engine status aggregator.
package fstatus_pkg;

    localparam int unsigned ERR_CNT_MSB   = 31;
    localparam int unsigned ERR_CNT_LSB   = 20;
    localparam int unsigned SYNC_CNT_MSB  = 19;
    localparam int unsigned SYNC_CNT_LSB  = 16;
    localparam int unsigned LOCKED_BIT    = 15;
    localparam int unsigned SYNC_LOST_BIT = 7;
    localparam int unsigned ERR_FLAG_W    = 7;
    localparam int unsigned SYNC_CNT_W    = SYNC_CNT_MSB - SYNC_CNT_LSB + 1;
    localparam int unsigned ERR_FIELD_W   = ERR_CNT_MSB - ERR_CNT_LSB + 1;
    localparam int unsigned TIMER_W       = 25;

    // err_in bit positions
    localparam int unsigned ERR_ADC0_OVR  = 0;
    localparam int unsigned ERR_ADC1_OVR  = 1;
    localparam int unsigned ERR_FFT_OVR   = 2;
    localparam int unsigned ERR_QUANT_OVR = 3;
    localparam int unsigned ERR_CT_ERR    = 4;
    localparam int unsigned ERR_TX_OVR    = 5;
    localparam int unsigned ERR_LINK_DOWN = 6;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        LOCKED,
        LOST
    } sync_state_e;

    function automatic logic [31:0] pack_status(
        input logic [ERR_FIELD_W-1:0] err_cnt,
        input logic [SYNC_CNT_W-1:0]  sync_cnt,
        input logic                   locked,
        input logic                   sync_lost,
        input logic [ERR_FLAG_W-1:0]  err_flags
    );
        logic [31:0] word;
        word                            = '0;
        word[ERR_CNT_MSB:ERR_CNT_LSB]   = err_cnt;
        word[SYNC_CNT_MSB:SYNC_CNT_LSB] = sync_cnt;
        word[LOCKED_BIT]                = locked;
        word[SYNC_LOST_BIT]             = sync_lost;
        word[ERR_FLAG_W-1:0]            = err_flags;
        return word;
    endfunction

endpackage

// File: rtl/fstatus_aggregator.sv
// Collects sticky error flags, error/sync counters and a sync watchdog into one
// registered 32-bit status word for the fstatus software register.
module fstatus_aggregator
    import fstatus_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT = 16777216,
    parameter int unsigned ERR_CNT_W    = 12
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  sync_in,
    input  logic [ERR_FLAG_W-1:0] err_in,
    input  logic                  status_clr,
    output logic [31:0]           status_out
);

    localparam logic [TIMER_W-1:0] TimerMax = TIMER_W'(SYNC_TIMEOUT - 1);

    sync_state_e           state_q;
    logic [TIMER_W-1:0]    timer_q;
    logic                  clr_q;
    logic [ERR_FLAG_W-1:0] err_flags_q, err_flags_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d;
    logic                  sync_lost_q, sync_lost_d;
    logic [31:0]           status_q;

    logic clr_edge;
    logic timeout_fire;
    logic capture;

    always_comb begin
        clr_edge     = status_clr & ~clr_q;
        // LOST never re-fires; only a fresh timeout can set sync_lost again
        timeout_fire = (state_q != LOST) && !sync_in && (timer_q == TimerMax);
        capture      = (state_q != WAIT_FIRST);

        err_flags_d = clr_edge ? '0 : err_flags_q;
        err_cnt_d   = clr_edge ? '0 : err_cnt_q;
        sync_cnt_d  = clr_edge ? '0 : sync_cnt_q;
        sync_lost_d = clr_edge ? 1'b0 : sync_lost_q;

        // Events are applied after the clear so that a same-cycle event survives it
        if (capture) begin
            err_flags_d = err_flags_d | err_in;
            if ((err_in != '0) && (err_cnt_d != '1)) begin
                err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
            end
        end
        sync_cnt_d  = sync_cnt_d + SYNC_CNT_W'(sync_in);
        sync_lost_d = sync_lost_d | timeout_fire;
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q <= WAIT_FIRST;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                WAIT_FIRST, LOCKED: begin
                    if (sync_in) begin
                        state_q <= LOCKED;
                        timer_q <= '0;
                    end else if (timer_q == TimerMax) begin
                        state_q <= LOST;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                LOST: begin
                    if (sync_in) begin
                        state_q <= LOCKED;
                        timer_q <= '0;
                    end
                end
                default: begin
                    state_q <= WAIT_FIRST;
                    timer_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            clr_q       <= 1'b0;
            err_flags_q <= '0;
            err_cnt_q   <= '0;
            sync_cnt_q  <= '0;
            sync_lost_q <= 1'b0;
            status_q    <= '0;
        end else begin
            clr_q       <= status_clr;
            err_flags_q <= err_flags_d;
            err_cnt_q   <= err_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            sync_lost_q <= sync_lost_d;
            // Single output stage, stable between edges for the downstream CDC
            status_q    <= pack_status(err_cnt_q, sync_cnt_q, state_q == LOCKED,
                                       sync_lost_q, err_flags_q);
        end
    end

    assign status_out = status_q;

endmodule

// File: tb/tb_fstatus_aggregator.sv
// Bench for fstatus_aggregator: vector table, directed corner sequences and a
// behavioural model feeding an expected-word scoreboard.
module tb_fstatus_aggregator;

    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_i;
    logic [6:0]  err;
    logic        clr;
    logic [31:0] status;

    always #5 clk = ~clk;

    fstatus_aggregator #(
        .SYNC_TIMEOUT(TO),
        .ERR_CNT_W   (12)
    ) dut (
        .user_clk  (clk),
        .user_rst_n(rst_n),
        .sync_in   (sync_i),
        .err_in    (err),
        .status_clr(clr),
        .status_out(status)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: 0 = waiting for first sync, 1 = locked, 2 = lost
    int          m_state;
    int unsigned m_timer;
    logic [6:0]  m_flags;
    int          m_cnt;
    int          m_scnt;
    bit          m_lost;
    bit          m_clr_prev;
    logic [31:0] exp_q[$];

    typedef struct {
        bit          s;
        logic [6:0]  e;
        bit          c;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [31:0] m_word();
        logic [11:0] c12;
        logic [3:0]  s4;
        c12 = m_cnt[11:0];
        s4  = m_scnt[3:0];
        return {c12, s4, (m_state == 1), 7'b0, m_lost, m_flags};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input logic [6:0] e, input bit c, input bit r);
        bit ce;
        if (!r) begin
            m_state = 0; m_timer = 0; m_flags = '0; m_cnt = 0; m_scnt = 0;
            m_lost = 0; m_clr_prev = 0;
        end else begin
            ce = c & ~m_clr_prev;
            if (ce) begin
                m_flags = '0; m_cnt = 0; m_scnt = 0; m_lost = 0;
            end
            if (m_state != 0) begin
                m_flags = m_flags | e;
                if (e != 0 && m_cnt < 4095) m_cnt++;
            end
            m_scnt = (m_scnt + int'(s)) % 16;
            if (s) begin
                m_state = 1;
                m_timer = 0;
            end else if (m_state != 2) begin
                if (m_timer == TO - 1) begin
                    m_state = 2;
                    m_lost  = 1;
                end else begin
                    m_timer++;
                end
            end
            m_clr_prev = c;
        end
    endtask

    // One clock: drive, advance the model, then compare the output one stage later
    task automatic step(input bit s, input logic [6:0] e, input bit c, input bit r);
        sync_i = s; err = e; clr = c; rst_n = r;
        model_edge(s, e, c, r);
        if (!r) exp_q.delete();
        exp_q.push_back(m_word());
        @(posedge clk);
        #1;
        if (!r) check("reset_word", status, 32'h0);
        else if (exp_q.size() >= 2) check("scoreboard", status, exp_q.pop_front());
    endtask

    initial begin
        sync_i = 0; err = '0; clr = 0; rst_n = 0;

        tbl[0]  = '{0, 7'h04, 0, 32'h0000_0000};
        tbl[1]  = '{1, 7'h00, 0, 32'h0000_0000};
        tbl[2]  = '{0, 7'h05, 0, 32'h0001_8000};
        tbl[3]  = '{0, 7'h05, 0, 32'h0011_8005};
        tbl[4]  = '{0, 7'h05, 0, 32'h0021_8005};
        tbl[5]  = '{0, 7'h00, 0, 32'h0031_8005};
        tbl[6]  = '{0, 7'h10, 1, 32'h0031_8005};
        tbl[7]  = '{0, 7'h00, 1, 32'h0010_8010};
        tbl[8]  = '{0, 7'h00, 1, 32'h0010_8010};
        tbl[9]  = '{1, 7'h00, 0, 32'h0010_8010};
        tbl[10] = '{0, 7'h00, 0, 32'h0011_8010};

        step(0, 7'h00, 0, 0);
        step(0, 7'h00, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 7'h00, 0, 1);
        check("idle_after_reset", status, 32'h0);
        step(0, 7'h04, 0, 1);
        step(0, 7'h00, 0, 1);
        check("err_ignored_wait_first", status, 32'h0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].s, tbl[i].e, tbl[i].c, 1);
            check($sformatf("vec%0d", i), status, tbl[i].exp);
        end

        // Watchdog: last sync two steps ago, timer is 1 here
        for (int i = 1; i <= 100; i++) begin
            step(0, 7'h00, 0, 1);
            if (i == 99) check("still_locked", {30'b0, status[15], status[7]}, 32'h2);
            if (i == 100) check("sync_lost", {30'b0, status[15], status[7]}, 32'h1);
        end
        step(1, 7'h00, 0, 1);
        step(0, 7'h00, 0, 1);
        check("relock", {26'b0, status[19:16], status[15], status[7]}, {26'b0, 4'd2, 2'b11});

        for (int i = 0; i < 5000; i++) step(0, 7'h01, 0, 1);
        check("err_cnt_saturate", {20'b0, status[31:20]}, 32'hFFF);

        step(0, 7'h00, 1, 1);
        step(0, 7'h00, 0, 1);
        for (int i = 0; i < 17; i++) begin
            step(1, 7'h00, 0, 1);
            step(0, 7'h00, 0, 1);
        end
        check("sync_cnt_wrap", {28'b0, status[19:16]}, 32'h1);

        // Reset wins over a simultaneous sync and clear edge
        step(1, 7'h7F, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 7'h04, 1, 1);
        check("post_reset_ignore", status, 32'h0);
        step(1, 7'h00, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 7'h04, 0, 1);

        // Timeout straight out of reset, without ever seeing a sync
        step(0, 7'h00, 0, 0);
        for (int i = 0; i < 101; i++) step(0, 7'h00, 0, 1);
        check("wait_first_timeout", {30'b0, status[15], status[7]}, 32'h1);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 29) == 0,
                 ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(0, 127)),
                 ($urandom_range(0, 7) == 0) ? ~clr : clr, 1);
        end
        step(0, 7'h00, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
